// File: rtl/periphery_io_ctrl.sv
// Host-side IO controller: opcode decode for channel memory access plus run/done sequencing.
// Optional cycle counter behind PERIPHERY_IO_CTRL_PERF_CNT_EN.
module periphery_io_ctrl #(
   parameter int INPUT_DATA_L = 32,
   parameter int IO_OPCODE_L  = 3,
   parameter int OUT_L        = 32,
   parameter int N_CH         = 4,
   parameter int ADDR_L       = 16,
   localparam int CH_L        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [INPUT_DATA_L-1:0] in,
   input  logic [IO_OPCODE_L-1:0]  io_opcode,
   input  logic                    reset_execution_io,
   input  logic                    enable_execution_io,
   output logic                    done_execution_io,
   output logic [OUT_L-1:0]        out,
   output logic [N_CH-1:0]         ch_enable,
   output logic [N_CH-1:0]         ch_rst_exec,
   input  logic [N_CH-1:0]         ch_done,
   output logic                    mem_wr_en,
   output logic                    mem_rd_en,
   output logic [CH_L-1:0]         mem_ch,
   output logic [ADDR_L-1:0]       mem_addr,
   output logic [INPUT_DATA_L-1:0] mem_wr_data,
   input  logic [OUT_L-1:0]        mem_rd_data,
   input  logic                    mem_rd_valid
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [IO_OPCODE_L-1:0] OP_SETA = IO_OPCODE_L'(1);
   localparam logic [IO_OPCODE_L-1:0] OP_SETC = IO_OPCODE_L'(2);
   localparam logic [IO_OPCODE_L-1:0] OP_WR   = IO_OPCODE_L'(3);
   localparam logic [IO_OPCODE_L-1:0] OP_RD   = IO_OPCODE_L'(4);
   localparam logic [IO_OPCODE_L-1:0] OP_MASK = IO_OPCODE_L'(5);
   localparam logic [IO_OPCODE_L-1:0] OP_STAT = IO_OPCODE_L'(6);
   localparam logic [IO_OPCODE_L-1:0] OP_CYC  = IO_OPCODE_L'(7);

   state_t state_q, state_d;
   logic start;
   logic [ADDR_L-1:0] addr_q, addr_d;
   logic [CH_L-1:0] ch_sel_q, ch_sel_d;
   logic [N_CH-1:0] mask_q, mask_d;
   logic [N_CH-1:0] sticky_q, sticky_d;
   logic err_q, err_d;
   logic [1:0] ign_q;
   logic rd_ok, busy, all_done;
   logic [OUT_L-1:0] status;

   logic done_q, done_d;
   logic [OUT_L-1:0] out_q, out_d;
   logic [N_CH-1:0] en_q, en_d;
   logic [N_CH-1:0] rstx_q, rstx_d;
   logic wr_q, wr_d, rd_q, rd_d;
   logic [CH_L-1:0] mch_q, mch_d;
   logic [ADDR_L-1:0] maddr_q, maddr_d;
   logic [INPUT_DATA_L-1:0] wdat_q, wdat_d;

`ifdef PERIPHERY_IO_CTRL_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;
`endif

   assign all_done = ((sticky_q | ch_done) & mask_q) == mask_q;
   assign rd_ok    = mem_rd_valid && (ign_q == 2'd0);
   assign busy     = !reset_execution_io && (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      unique case (state_q)
         IDLE: if (enable_execution_io && mask_q != '0) begin
            state_d = RUN;
            start   = 1'b1;
         end
         RUN:  if (all_done) state_d = DONE;
         DONE: if (!enable_execution_io) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (reset_execution_io) begin
         state_d = IDLE;
         start   = 1'b0;
      end
   end

   always_comb begin
      status = '0;
      status[N_CH+2:0] = {err_q, sticky_q, state_q};
      addr_d   = addr_q;
      ch_sel_d = ch_sel_q;
      mask_d   = mask_q;
      err_d    = reset_execution_io ? 1'b0 : err_q;
      out_d    = out_q;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      mch_d    = mch_q;
      maddr_d  = maddr_q;
      wdat_d   = wdat_q;
      rstx_d   = reset_execution_io ? mask_q : '0;
`ifdef PERIPHERY_IO_CTRL_PERF_CNT_EN
      cnt_d = cnt_q;
      if (start) cnt_d = '0;
      else if (state_q == RUN && !reset_execution_io && cnt_q != '1)
         cnt_d = cnt_q + 32'd1;
`endif
      // a fresh run starts with no completed channels
      if (reset_execution_io || start) sticky_d = '0;
      else if (state_q == RUN) sticky_d = sticky_q | (ch_done & mask_q);
      else sticky_d = sticky_q;
      if (!reset_execution_io && state_q == IDLE
          && enable_execution_io && mask_q == '0)
         err_d = 1'b1;
      case (io_opcode)
         OP_SETA: addr_d = in[ADDR_L-1:0];
         OP_SETC: begin
            if (in >= INPUT_DATA_L'(N_CH)) err_d = 1'b1;
            else ch_sel_d = in[CH_L-1:0];
         end
         OP_WR: begin
            if (busy) err_d = 1'b1;
            else begin
               wr_d    = 1'b1;
               maddr_d = addr_q;
               mch_d   = ch_sel_q;
               wdat_d  = in;
               addr_d  = addr_q + 1'b1;
            end
         end
         OP_RD: begin
            if (busy) err_d = 1'b1;
            else begin
               rd_d    = 1'b1;
               maddr_d = addr_q;
               mch_d   = ch_sel_q;
               addr_d  = addr_q + 1'b1;
            end
         end
         OP_MASK: begin
            if (busy) err_d = 1'b1;
            else mask_d = in[N_CH-1:0];
         end
         OP_STAT: out_d = status;
`ifdef PERIPHERY_IO_CTRL_PERF_CNT_EN
         OP_CYC: out_d = OUT_L'(cnt_q);
`endif
         default: ;
      endcase
      if (rd_ok) out_d = mem_rd_data;
      en_d   = (state_d == RUN) ? mask_d : '0;
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         ch_sel_q <= '0;
         mask_q   <= '1;
         sticky_q <= '0;
         err_q    <= 1'b0;
         ign_q    <= 2'd2;
         done_q   <= 1'b0;
         out_q    <= '0;
         en_q     <= '0;
         rstx_q   <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         mch_q    <= '0;
         maddr_q  <= '0;
         wdat_q   <= '0;
`ifdef PERIPHERY_IO_CTRL_PERF_CNT_EN
         cnt_q    <= '0;
`endif
      end else begin
         addr_q   <= addr_d;
         ch_sel_q <= ch_sel_d;
         mask_q   <= mask_d;
         sticky_q <= sticky_d;
         err_q    <= err_d;
         ign_q    <= (ign_q != 2'd0) ? ign_q - 2'd1 : 2'd0;
         done_q   <= done_d;
         out_q    <= out_d;
         en_q     <= en_d;
         rstx_q   <= rstx_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         mch_q    <= mch_d;
         maddr_q  <= maddr_d;
         wdat_q   <= wdat_d;
`ifdef PERIPHERY_IO_CTRL_PERF_CNT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign done_execution_io = done_q;
   assign out               = out_q;
   assign ch_enable         = en_q;
   assign ch_rst_exec       = rstx_q;
   assign mem_wr_en         = wr_q;
   assign mem_rd_en         = rd_q;
   assign mem_ch            = mch_q;
   assign mem_addr          = maddr_q;
   assign mem_wr_data       = wdat_q;

endmodule
